// File: rtl/syscon_arb_pkg.sv
// Shared types and constants for the syscon Wishbone arbiter.
package syscon_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_e;

    localparam int unsigned TO_W = 10;

endpackage

// File: rtl/syscon_arb_timeout.sv
// Watchdog counter: counts unacknowledged strobe cycles and pulses fire_o at Limit.
module syscon_arb_timeout
    import syscon_arb_pkg::*;
#(
    parameter int unsigned Limit = 255
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic count_i,
    output logic fire_o
);

    logic [TO_W-1:0] cnt_q;
    logic [TO_W-1:0] cnt_d;

    // A clear in the same cycle (slave ack) suppresses the pulse.
    assign fire_o = (cnt_q == TO_W'(Limit)) && !clear_i;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i || fire_o) begin
            cnt_d = '0;
        end else if (count_i) begin
            cnt_d = cnt_q + TO_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/syscon_wb_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of the syscon slave port.
// Define SYSCON_ARB_TIMEOUT_EN to enable the unacknowledged-cycle watchdog.
module syscon_wb_arbiter
    import syscon_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_m0_adr,
    input  logic [31:0] i_m0_dat,
    input  logic [3:0]  i_m0_sel,
    input  logic        i_m0_we,
    input  logic        i_m0_cyc,
    input  logic        i_m0_stb,
    output logic [31:0] o_m0_rdt,
    output logic        o_m0_ack,
    output logic        o_m0_err,
    input  logic [31:0] i_m1_adr,
    input  logic [31:0] i_m1_dat,
    input  logic [3:0]  i_m1_sel,
    input  logic        i_m1_we,
    input  logic        i_m1_cyc,
    input  logic        i_m1_stb,
    output logic [31:0] o_m1_rdt,
    output logic        o_m1_ack,
    output logic        o_m1_err,
    output logic [31:0] o_s_adr,
    output logic [31:0] o_s_dat,
    output logic [3:0]  o_s_sel,
    output logic        o_s_we,
    output logic        o_s_cyc,
    output logic        o_s_stb,
    input  logic [31:0] i_s_rdt,
    input  logic        i_s_ack
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 1023) begin : gen_bad_timeout
        $error("TIMEOUT_CYCLES must be within 1..1023");
    end

    arb_state_e state_q;
    logic       last_q;
    logic       gnt0;
    logic       gnt1;

    // Ties go to the master that was not granted last; grant held until owner drops cyc.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (i_m0_cyc && (!i_m1_cyc || last_q)) begin
                        state_q <= GNT0;
                        last_q  <= 1'b0;
                    end else if (i_m1_cyc) begin
                        state_q <= GNT1;
                        last_q  <= 1'b1;
                    end
                end
                GNT0: if (!i_m0_cyc) state_q <= IDLE;
                GNT1: if (!i_m1_cyc) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt0 = (state_q == GNT0);
    assign gnt1 = (state_q == GNT1);

    always_comb begin
        o_s_adr = '0;
        o_s_dat = '0;
        o_s_sel = '0;
        o_s_we  = 1'b0;
        o_s_cyc = 1'b0;
        o_s_stb = 1'b0;
        if (gnt0) begin
            o_s_adr = i_m0_adr;
            o_s_dat = i_m0_dat;
            o_s_sel = i_m0_sel;
            o_s_we  = i_m0_we;
            o_s_cyc = i_m0_cyc;
            o_s_stb = i_m0_stb;
        end else if (gnt1) begin
            o_s_adr = i_m1_adr;
            o_s_dat = i_m1_dat;
            o_s_sel = i_m1_sel;
            o_s_we  = i_m1_we;
            o_s_cyc = i_m1_cyc;
            o_s_stb = i_m1_stb;
        end
    end

    always_comb begin
        o_m0_ack = gnt0 & i_s_ack;
        o_m1_ack = gnt1 & i_s_ack;
        o_m0_rdt = gnt0 ? i_s_rdt : '0;
        o_m1_rdt = gnt1 ? i_s_rdt : '0;
    end

`ifdef SYSCON_ARB_TIMEOUT_EN
    logic to_fire;

    // Holding the counter clear while idle guarantees a fresh count on every grant.
    syscon_arb_timeout #(
        .Limit (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i   (i_clk),
        .rst_ni  (i_rst_n),
        .clear_i ((state_q == IDLE) || i_s_ack),
        .count_i (o_s_stb && !i_s_ack),
        .fire_o  (to_fire)
    );

    assign o_m0_err = gnt0 & to_fire;
    assign o_m1_err = gnt1 & to_fire;
`else
    assign o_m0_err = 1'b0;
    assign o_m1_err = 1'b0;
`endif

endmodule

// File: tb/tb_syscon_wb_arbiter.sv
// Directed bench for syscon_wb_arbiter with a read-data scoreboard.
module tb_syscon_wb_arbiter;

    logic        clk = 1'b0;
    logic        i_rst_n;
    logic [31:0] i_m0_adr, i_m0_dat, i_m1_adr, i_m1_dat, i_s_rdt;
    logic [3:0]  i_m0_sel, i_m1_sel;
    logic        i_m0_we, i_m0_cyc, i_m0_stb, i_m1_we, i_m1_cyc, i_m1_stb, i_s_ack;
    logic [31:0] o_m0_rdt, o_m1_rdt, o_s_adr, o_s_dat;
    logic [3:0]  o_s_sel;
    logic        o_m0_ack, o_m0_err, o_m1_ack, o_m1_err, o_s_we, o_s_cyc, o_s_stb;

    int n_cmp = 0;
    int n_err = 0;
    logic [32:0] sb[$];

    localparam logic [31:0] A0 = 32'h0000_0100;
    localparam logic [31:0] A1 = 32'h0000_0200;

    always #5 clk = ~clk;

    syscon_wb_arbiter #(
        .TIMEOUT_CYCLES (8)
    ) dut (
        .i_clk    (clk),
        .i_rst_n  (i_rst_n),
        .i_m0_adr (i_m0_adr),
        .i_m0_dat (i_m0_dat),
        .i_m0_sel (i_m0_sel),
        .i_m0_we  (i_m0_we),
        .i_m0_cyc (i_m0_cyc),
        .i_m0_stb (i_m0_stb),
        .o_m0_rdt (o_m0_rdt),
        .o_m0_ack (o_m0_ack),
        .o_m0_err (o_m0_err),
        .i_m1_adr (i_m1_adr),
        .i_m1_dat (i_m1_dat),
        .i_m1_sel (i_m1_sel),
        .i_m1_we  (i_m1_we),
        .i_m1_cyc (i_m1_cyc),
        .i_m1_stb (i_m1_stb),
        .o_m1_rdt (o_m1_rdt),
        .o_m1_ack (o_m1_ack),
        .o_m1_err (o_m1_err),
        .o_s_adr  (o_s_adr),
        .o_s_dat  (o_s_dat),
        .o_s_sel  (o_s_sel),
        .o_s_we   (o_s_we),
        .o_s_cyc  (o_s_cyc),
        .o_s_stb  (o_s_stb),
        .i_s_rdt  (i_s_rdt),
        .i_s_ack  (i_s_ack)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; the slave ack is a one-cycle input.
    task automatic tick();
        @(posedge clk);
        #1;
        i_s_ack = 1'b0;
    endtask

    // Let inputs settle, then check any acknowledged beat against the scoreboard.
    task automatic look();
        logic [32:0] e;
        #1;
        chk1("ack_onehot", o_m0_ack & o_m1_ack, 1'b0);
        if (o_m0_ack || o_m1_ack) begin
            if (sb.size() == 0) begin
                chk1("sb_underflow", o_m0_ack | o_m1_ack, 1'b0);
            end else begin
                e = sb.pop_front();
                chk1("sb_owner", o_m1_ack, e[32]);
                chk32("sb_rdt", o_m1_ack ? o_m1_rdt : o_m0_rdt, e[31:0]);
                chk32("sb_other_rdt", o_m1_ack ? o_m0_rdt : o_m1_rdt, 32'h0);
            end
        end
    endtask

    task automatic ack_beat(input logic m, input logic [31:0] data);
        sb.push_back({m, data});
        i_s_rdt = data;
        i_s_ack = 1'b1;
        look();
    endtask

    task automatic req0(input logic on, input logic [31:0] adr);
        i_m0_cyc = on;
        i_m0_stb = on;
        i_m0_adr = adr;
    endtask

    task automatic req1(input logic on, input logic [31:0] adr);
        i_m1_cyc = on;
        i_m1_stb = on;
        i_m1_adr = adr;
    endtask

    task automatic chk_all_zero(input string tag);
        chk32({tag, "_adr"}, o_s_adr, 32'h0);
        chk32({tag, "_dat"}, o_s_dat, 32'h0);
        chk32({tag, "_rdt"}, o_m0_rdt | o_m1_rdt, 32'h0);
        chk32({tag, "_ctl"}, {21'h0, o_s_sel, o_s_we, o_s_cyc, o_s_stb,
                              o_m0_ack, o_m1_ack, o_m0_err, o_m1_err}, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        i_rst_n = 1'b0;
        i_m0_dat = '0; i_m0_sel = '0; i_m0_we = 1'b0;
        i_m1_dat = '0; i_m1_sel = '0; i_m1_we = 1'b0;
        req0(1'b0, '0);
        req1(1'b0, '0);
        i_s_rdt = '0;
        i_s_ack = 1'b0;

        // Reset held while inputs toggle.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            i_m0_adr = $urandom(); i_m1_adr = $urandom();
            i_m0_dat = $urandom(); i_m1_dat = $urandom();
            i_m0_sel = 4'($urandom()); i_m1_sel = 4'($urandom());
            i_m0_we = 1'($urandom_range(0, 1)); i_m1_we = 1'($urandom_range(0, 1));
            i_m0_cyc = 1'b1; i_m0_stb = 1'b1;
            i_m1_cyc = 1'($urandom_range(0, 1)); i_m1_stb = 1'b1;
            i_s_rdt = $urandom(); i_s_ack = 1'($urandom_range(0, 1));
            #1;
            chk_all_zero("rst_hold");
        end
        i_m0_dat = '0; i_m0_sel = 4'hF; i_m0_we = 1'b0;
        i_m1_dat = '0; i_m1_sel = 4'hF; i_m1_we = 1'b0;
        req0(1'b0, '0);
        req1(1'b0, '0);
        i_s_ack = 1'b0;
        #1;
        i_rst_n = 1'b1;

        // Single master read.
        tick(); req0(1'b1, 32'h0000_0010); look();
        chk1("single_idle_no_fwd", o_s_cyc, 1'b0);
        tick(); look();
        chk1("single_stb_lat", o_s_stb, 1'b1);
        chk32("single_adr", o_s_adr, 32'h0000_0010);
        chk1("single_we", o_s_we, 1'b0);
        tick(); look();
        chk1("single_wait_ack", o_m0_ack, 1'b0);
        tick(); ack_beat(1'b0, 32'hDEAD_BEEF);
        chk1("single_ack", o_m0_ack, 1'b1);
        chk1("single_m1_ack", o_m1_ack, 1'b0);
        tick(); req0(1'b0, '0); look();

        // Reset asserted mid-grant.
        tick(); req0(1'b1, 32'h0000_0020); look();
        tick(); look();
        chk1("rstmid_pre", o_s_cyc, 1'b1);
        i_s_ack = 1'b1;
        #1;
        i_rst_n = 1'b0;
        #1;
        chk1("rstmid_cyc", o_s_cyc, 1'b0);
        chk1("rstmid_ack", o_m0_ack, 1'b0);
        i_s_ack = 1'b0;
        req0(1'b0, '0);
        #1;
        i_rst_n = 1'b1;

        // Simultaneous requests after reset: m0 first, m1 after one idle cycle.
        tick(); req0(1'b1, A0); req1(1'b1, A1); look();
        chk1("sim_idle", o_s_cyc, 1'b0);
        tick(); look();
        chk32("sim_first", o_s_adr, A0);
        ack_beat(1'b0, 32'h0000_A0A0);
        tick(); req0(1'b0, A0); look();
        tick(); look();
        chk1("sim_gap", o_s_cyc, 1'b0);
        tick(); look();
        chk32("sim_second", o_s_adr, A1);
        ack_beat(1'b1, 32'h0000_B1B1);
        tick(); req1(1'b0, A1); look();
        tick(); req0(1'b1, A0); req1(1'b1, A1); look();

        // Fairness: both keep requesting, each owner does one beat and re-requests.
        for (int r = 0; r < 6; r++) begin
            int w;
            logic expm;
            expm = r[0];
            w = 0;
            do begin
                tick(); look(); w++;
            end while (!o_s_stb && w < 4);
            chk1("fair_stb", o_s_stb, 1'b1);
            chk32("fair_owner", o_s_adr, expm ? A1 : A0);
            ack_beat(expm, 32'h0000_1000 + 32'(r));
            tick();
            if (expm) req1(1'b0, A1); else req0(1'b0, A0);
            look();
            tick();
            if (expm) req1(1'b1, A1); else req0(1'b1, A0);
            look();
            chk1("fair_idle_gap", o_s_cyc, 1'b0);
        end
        tick(); req0(1'b0, A0); req1(1'b0, A1); look();
        tick(); look();
        chk1("lock_pre_idle", o_s_cyc, 1'b0);

        // Lock: m1 keeps the bus for four beats while m0 waits.
        tick(); req1(1'b1, A1); i_m1_we = 1'b1; i_m1_dat = 32'h1234_5678; i_m1_sel = 4'h3;
        look();
        tick(); req0(1'b1, A0); look();
        chk32("lock_adr", o_s_adr, A1);
        chk32("lock_dat", o_s_dat, 32'h1234_5678);
        chk32("lock_sel", {28'h0, o_s_sel}, 32'h3);
        chk1("lock_we", o_s_we, 1'b1);
        for (int b = 0; b < 4; b++) begin
            ack_beat(1'b1, 32'h0000_C000 + 32'(b));
            chk32("lock_hold", o_s_adr, A1);
            chk1("lock_m0_ack", o_m0_ack, 1'b0);
            if (b < 3) begin
                tick(); look();
            end
        end
        tick(); req1(1'b0, A1); i_m1_we = 1'b0; look();
        tick(); look();
        chk1("lock_gap", o_s_cyc, 1'b0);
        tick(); look();
        chk32("lock_after", o_s_adr, A0);
        ack_beat(1'b0, 32'h0000_D00D);
        tick(); req0(1'b0, A0); look();
        tick(); look();
        req0(1'b1, A0);

        // Stalled slave: watchdog behaviour depends on the build.
`ifdef SYSCON_ARB_TIMEOUT_EN
        for (int i = 0; i < 10; i++) begin
            tick(); look();
            chk1("to_err", o_m0_err, i == 8);
            chk1("to_m1_err", o_m1_err, 1'b0);
        end
        tick(); req0(1'b0, A0); look();
        tick(); look();
        req0(1'b1, A0);
        for (int i = 0; i < 8; i++) begin
            tick(); look();
            chk1("to_pre_err", o_m0_err, 1'b0);
        end
        tick(); ack_beat(1'b0, 32'h0000_E0E0);
        chk1("to_same_ack", o_m0_ack, 1'b1);
        chk1("to_same_err", o_m0_err, 1'b0);
`else
        for (int i = 0; i < 10; i++) begin
            tick(); look();
            chk1("noto_m0_err", o_m0_err, 1'b0);
            chk1("noto_m1_err", o_m1_err, 1'b0);
        end
        chk1("noto_stb_held", o_s_stb, 1'b1);
`endif
        tick(); req0(1'b0, A0); look();
        tick(); look();
        chk_all_zero("final_idle");
        chk32("sb_drained", 32'(sb.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
